// File: rtl/ram_wr_buffer_if.sv
// Bundle for the write buffer: command channel, MXU row stream, RAM write port and status.
// The slave modport is the buffer itself; master is whoever drives commands/rows and accepts writes.
interface ram_wr_buffer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 128,
  parameter int STRB_WIDTH = 16
);
  logic                  ctrl_wr_buff_vld;
  logic                  ctrl_wr_buff_rdy;
  logic [ADDR_WIDTH-1:0] ctrl_wr_buff_start_addr;
  logic [3:0]            ctrl_wr_buff_ent_num;
  logic                  ctrl_wr_buff_dir;

  logic [STRB_WIDTH-1:0] mxu_wr_buff_vld;
  logic [DATA_WIDTH-1:0] mxu_wr_buff_data;
  logic                  wr_buff_mxu_rdy;

  logic                  ram_write_vld;
  logic                  ram_write_rdy;
  logic [ADDR_WIDTH-1:0] ram_write_addr;
  logic [DATA_WIDTH-1:0] ram_write_data;
  logic [STRB_WIDTH-1:0] ram_write_strb;

  logic                  wr_buff_busy;
  logic                  wr_buff_done;

  modport slave (
    input  ctrl_wr_buff_vld, ctrl_wr_buff_start_addr, ctrl_wr_buff_ent_num, ctrl_wr_buff_dir,
    output ctrl_wr_buff_rdy,
    input  mxu_wr_buff_vld, mxu_wr_buff_data,
    output wr_buff_mxu_rdy,
    output ram_write_vld, ram_write_addr, ram_write_data, ram_write_strb,
    input  ram_write_rdy,
    output wr_buff_busy, wr_buff_done
  );

  modport master (
    output ctrl_wr_buff_vld, ctrl_wr_buff_start_addr, ctrl_wr_buff_ent_num, ctrl_wr_buff_dir,
    input  ctrl_wr_buff_rdy,
    output mxu_wr_buff_vld, mxu_wr_buff_data,
    input  wr_buff_mxu_rdy,
    input  ram_write_vld, ram_write_addr, ram_write_data, ram_write_strb,
    output ram_write_rdy,
    input  wr_buff_busy, wr_buff_done
  );
endinterface

// File: rtl/ram_wr_buffer.sv
// Queues MXU result rows in a small FIFO and issues byte-strobed RAM writes with addresses
// assigned at push time; signals done once every row of the command has been written.
module ram_wr_buffer #(
  parameter int ENT_NUM    = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 128,
  parameter int STRB_WIDTH = 16
) (
  input logic         clk,
  input logic         rst,
  ram_wr_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(ENT_NUM);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ENT_NUM);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RECV  = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] start_addr_reg;
  logic [3:0]            ent_num_reg;
  logic                  dir_reg;
  logic [3:0]            rows_reg;
  logic [ADDR_WIDTH-1:0] offset_reg;

  logic [ENT_W-1:0]      mem [ENT_NUM];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_inc;
  logic [CNT_W-1:0]      count_reg;
  logic                  out_vld_reg;
  logic [ENT_W-1:0]      out_reg;

  logic                  cmd_take;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  mxu_rdy;
  logic                  push;
  logic                  pop;
  logic                  done;
  logic [ADDR_WIDTH-1:0] push_addr;
  logic [ENT_W-1:0]      push_ent;

  assign cmd_take   = (state_reg == IDLE) && bus.ctrl_wr_buff_vld;
  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign mxu_rdy    = (state_reg == RECV) && !fifo_full;
  assign push       = mxu_rdy && (|bus.mxu_wr_buff_vld);
  assign pop        = out_vld_reg && bus.ram_write_rdy;
  assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

  // Address is fixed when the row enters the queue, so write order equals push order.
  assign push_addr = dir_reg ? (start_addr_reg - offset_reg) : (start_addr_reg + offset_reg);
  assign push_ent  = {push_addr, bus.mxu_wr_buff_data, bus.mxu_wr_buff_vld};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.ctrl_wr_buff_vld) begin
          state_next = RECV;
        end
      end
      RECV: begin
        if (push && (rows_reg == ent_num_reg)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !out_vld_reg) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_addr_reg <= '0;
      ent_num_reg    <= '0;
      dir_reg        <= 1'b0;
      rows_reg       <= '0;
      offset_reg     <= '0;
    end else if (cmd_take) begin
      start_addr_reg <= bus.ctrl_wr_buff_start_addr;
      ent_num_reg    <= bus.ctrl_wr_buff_ent_num;
      dir_reg        <= bus.ctrl_wr_buff_dir;
      rows_reg       <= '0;
      offset_reg     <= '0;
    end else if (push) begin
      rows_reg       <= rows_reg + 4'd1;
      offset_reg     <= offset_reg + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_ent;
    end
  end

  // count includes the entry sitting in the output register; it leaves only on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      out_vld_reg <= 1'b0;
      out_reg     <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_inc;
      end
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
      if (!out_vld_reg || pop) begin
        if (out_vld_reg && (count_reg > ONE_CNT)) begin
          out_reg     <= mem[rd_ptr_inc];
          out_vld_reg <= 1'b1;
        end else if (push) begin
          // Queue drains to nothing this cycle: forward the incoming row straight to the port.
          out_reg     <= push_ent;
          out_vld_reg <= 1'b1;
        end else begin
          out_vld_reg <= 1'b0;
        end
      end
    end
  end

  assign bus.ram_write_vld  = out_vld_reg;
  assign bus.ram_write_addr = out_reg[ENT_W-1 -: ADDR_WIDTH];
  assign bus.ram_write_data = out_reg[STRB_WIDTH +: DATA_WIDTH];
  assign bus.ram_write_strb = out_reg[STRB_WIDTH-1:0];

  assign bus.wr_buff_mxu_rdy  = mxu_rdy;
  assign bus.ctrl_wr_buff_rdy = (state_reg == IDLE);
  assign bus.wr_buff_busy     = (state_reg != IDLE);
  assign bus.wr_buff_done     = done;
endmodule
